// File: rtl/issue_queue_pkg.sv
// Shared constants and the issue queue entry layout; entry fields are sized
// from the IQ_* constants, so the top's width parameters must agree with them.
package issue_queue_pkg;

    localparam int IQ_DEPTH   = 8;
    localparam int IQ_XLEN    = 32;
    localparam int IQ_TAG_W   = 6;
    localparam int IQ_OPC_W   = 4;
    localparam int IQ_NUM_CDB = 2;

    typedef struct packed {
        logic                valid;
        logic [IQ_TAG_W-1:0] rd_tag;
        logic [IQ_OPC_W-1:0] opcode;
        logic [IQ_XLEN-1:0]  rs_data;
        logic [IQ_TAG_W-1:0] rs_tag;
        logic                rs_val;
        logic [IQ_XLEN-1:0]  rt_data;
        logic [IQ_TAG_W-1:0] rt_tag;
        logic                rt_val;
    } iq_entry_t;

endpackage

// File: rtl/iq_oldest_picker.sv
// Oldest-first priority encoder: grants the lowest-index set bit of ready_i.
// Purely combinational, no backpressure; grant_o is all-zero when nothing is ready.
module iq_oldest_picker #(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] ready_i,
    output logic [DEPTH-1:0] grant_o,
    output logic [IDX_W-1:0] idx_o
);

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        // Walk from the youngest slot down so the oldest ready slot is the last writer.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready_i[i]) begin
                grant_o    = '0;
                grant_o[i] = 1'b1;
                idx_o      = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/generic_issue_queue.sv
// Compacted age-ordered issue queue with CDB wakeup; issue is combinational from registered
// entries, dispatch_ready depends combinationally on issue_ready. Optional ISSUE_QUEUE_CDB_BYPASS_EN.
module generic_issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH   = IQ_DEPTH,
    parameter int XLEN    = IQ_XLEN,
    parameter int TAG_W   = IQ_TAG_W,
    parameter int OPC_W   = IQ_OPC_W,
    parameter int NUM_CDB = IQ_NUM_CDB
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       dispatch_valid,
    output logic                       dispatch_ready,
    input  logic [XLEN-1:0]            dispatch_rs_data,
    input  logic [XLEN-1:0]            dispatch_rt_data,
    input  logic [TAG_W-1:0]           dispatch_rs_tag,
    input  logic [TAG_W-1:0]           dispatch_rt_tag,
    input  logic                       dispatch_rs_val,
    input  logic                       dispatch_rt_val,
    input  logic [OPC_W-1:0]           dispatch_opcode,
    input  logic [TAG_W-1:0]           dispatch_rd_tag,
    input  logic [NUM_CDB-1:0]         cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]   cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]    cdb_data,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [XLEN-1:0]            issue_rs_data,
    output logic [XLEN-1:0]            issue_rt_data,
    output logic [TAG_W-1:0]           issue_rd_tag,
    output logic [OPC_W-1:0]           issue_opcode,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    iq_entry_t              entries_q [DEPTH];
    iq_entry_t              entries_d [DEPTH];
    logic      [CNT_W-1:0]  count_q, count_d;
    logic      [DEPTH-1:0]  ready;
    logic      [DEPTH-1:0]  pick_grant;
    logic      [IDX_W-1:0]  pick_idx;
    logic                   issue_fire;
    logic                   dispatch_fire;
    logic      [CNT_W-1:0]  wr_slot;
    iq_entry_t              new_entry;

    // Returns {hit, data}; scanning from the top port down lets port 0 win ties.
    function automatic logic [XLEN:0] cdb_match(
        input logic [TAG_W-1:0]         tag,
        input logic [NUM_CDB-1:0]       vld,
        input logic [NUM_CDB*TAG_W-1:0] tags,
        input logic [NUM_CDB*XLEN-1:0]  data
    );
        cdb_match = '0;
        for (int p = NUM_CDB - 1; p >= 0; p--) begin
            if (vld[p] && (tags[p*TAG_W +: TAG_W] == tag)) begin
                cdb_match = {1'b1, data[p*XLEN +: XLEN]};
            end
        end
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = entries_q[i].valid & entries_q[i].rs_val & entries_q[i].rt_val;
        end
    end

    iq_oldest_picker #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_picker (
        .ready_i (ready),
        .grant_o (pick_grant),
        .idx_o   (pick_idx)
    );

    assign issue_valid    = !flush && (|ready);
    assign issue_fire     = issue_valid && issue_ready;
    assign dispatch_ready = !flush && ((count_q < CNT_W'(DEPTH)) || issue_fire);
    assign dispatch_fire  = dispatch_valid && dispatch_ready;
    assign wr_slot        = issue_fire ? (count_q - 1'b1) : count_q;
    assign count          = count_q;

    always_comb begin
        issue_rs_data = '0;
        issue_rt_data = '0;
        issue_rd_tag  = '0;
        issue_opcode  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (issue_valid && pick_grant[i]) begin
                issue_rs_data = entries_q[i].rs_data;
                issue_rt_data = entries_q[i].rt_data;
                issue_rd_tag  = entries_q[i].rd_tag;
                issue_opcode  = entries_q[i].opcode;
            end
        end
    end

    always_comb begin
`ifdef ISSUE_QUEUE_CDB_BYPASS_EN
        logic [XLEN:0] byp;
        byp = '0;
`endif
        new_entry         = '0;
        new_entry.valid   = 1'b1;
        new_entry.rd_tag  = dispatch_rd_tag;
        new_entry.opcode  = dispatch_opcode;
        new_entry.rs_data = dispatch_rs_data;
        new_entry.rs_tag  = dispatch_rs_tag;
        new_entry.rs_val  = dispatch_rs_val;
        new_entry.rt_data = dispatch_rt_data;
        new_entry.rt_tag  = dispatch_rt_tag;
        new_entry.rt_val  = dispatch_rt_val;
`ifdef ISSUE_QUEUE_CDB_BYPASS_EN
        if (!dispatch_rs_val) begin
            byp = cdb_match(dispatch_rs_tag, cdb_valid, cdb_tag, cdb_data);
            if (byp[XLEN]) begin
                new_entry.rs_data = byp[XLEN-1:0];
                new_entry.rs_val  = 1'b1;
            end
        end
        if (!dispatch_rt_val) begin
            byp = cdb_match(dispatch_rt_tag, cdb_valid, cdb_tag, cdb_data);
            if (byp[XLEN]) begin
                new_entry.rt_data = byp[XLEN-1:0];
                new_entry.rt_val  = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        logic [XLEN:0] hit;
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i] = entries_q[i];
        end
        count_d = count_q;

        // Collapse the hole left by the issued entry; the top slot always empties.
        if (issue_fire) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (IDX_W'(i) >= pick_idx) begin
                    entries_d[i] = entries_q[i+1];
                end
            end
            entries_d[DEPTH-1] = '0;
        end

        // Wakeup lands in the post-shift slot, so it is applied after the collapse.
        for (int i = 0; i < DEPTH; i++) begin
            if (entries_d[i].valid && !entries_d[i].rs_val) begin
                hit = cdb_match(entries_d[i].rs_tag, cdb_valid, cdb_tag, cdb_data);
                if (hit[XLEN]) begin
                    entries_d[i].rs_data = hit[XLEN-1:0];
                    entries_d[i].rs_val  = 1'b1;
                end
            end
            if (entries_d[i].valid && !entries_d[i].rt_val) begin
                hit = cdb_match(entries_d[i].rt_tag, cdb_valid, cdb_tag, cdb_data);
                if (hit[XLEN]) begin
                    entries_d[i].rt_data = hit[XLEN-1:0];
                    entries_d[i].rt_val  = 1'b1;
                end
            end
            if (dispatch_fire && (wr_slot == CNT_W'(i))) begin
                entries_d[i] = new_entry;
            end
        end

        case ({dispatch_fire, issue_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i] = '0;
            end
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_generic_issue_queue.sv
// Randomized and directed bench for generic_issue_queue against a queue-based reference model.
module tb_generic_issue_queue;

    localparam int DEPTH   = 8;
    localparam int XLEN    = 32;
    localparam int TAG_W   = 6;
    localparam int OPC_W   = 4;
    localparam int NUM_CDB = 2;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     flush;
    logic                     dispatch_valid;
    logic                     dispatch_ready;
    logic [XLEN-1:0]          dispatch_rs_data, dispatch_rt_data;
    logic [TAG_W-1:0]         dispatch_rs_tag, dispatch_rt_tag;
    logic                     dispatch_rs_val, dispatch_rt_val;
    logic [OPC_W-1:0]         dispatch_opcode;
    logic [TAG_W-1:0]         dispatch_rd_tag;
    logic [NUM_CDB-1:0]       cdb_valid;
    logic [NUM_CDB*TAG_W-1:0] cdb_tag;
    logic [NUM_CDB*XLEN-1:0]  cdb_data;
    logic                     issue_valid;
    logic                     issue_ready;
    logic [XLEN-1:0]          issue_rs_data, issue_rt_data;
    logic [TAG_W-1:0]         issue_rd_tag;
    logic [OPC_W-1:0]         issue_opcode;
    logic [CNT_W-1:0]         count;

    generic_issue_queue #(
        .DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W), .OPC_W(OPC_W), .NUM_CDB(NUM_CDB)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_rs_data(dispatch_rs_data), .dispatch_rt_data(dispatch_rt_data),
        .dispatch_rs_tag(dispatch_rs_tag), .dispatch_rt_tag(dispatch_rt_tag),
        .dispatch_rs_val(dispatch_rs_val), .dispatch_rt_val(dispatch_rt_val),
        .dispatch_opcode(dispatch_opcode), .dispatch_rd_tag(dispatch_rd_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs_data(issue_rs_data), .issue_rt_data(issue_rt_data),
        .issue_rd_tag(issue_rd_tag), .issue_opcode(issue_opcode),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TAG_W-1:0] rd_tag;
        logic [OPC_W-1:0] opc;
        logic [XLEN-1:0]  rs_data, rt_data;
        logic [TAG_W-1:0] rs_tag, rt_tag;
        bit               rs_val, rt_val;
    } m_entry_t;

    m_entry_t model[$];
    int n_checks = 0;
    int n_fail   = 0;

    logic             last_iv, last_dr;
    logic [TAG_W-1:0] last_rd;
    logic [XLEN-1:0]  last_rs;
    logic [CNT_W-1:0] last_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Lowest CDB port carrying a valid matching tag, if any.
    function automatic bit cdb_lookup(input logic [TAG_W-1:0] tag, output logic [XLEN-1:0] data);
        data = '0;
        for (int p = 0; p < NUM_CDB; p++) begin
            if (cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == tag) begin
                data = cdb_data[p*XLEN +: XLEN];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic int oldest_ready();
        for (int i = 0; i < model.size(); i++)
            if (model[i].rs_val && model[i].rt_val) return i;
        return -1;
    endfunction

    task automatic check_outputs();
        int  sel;
        bit  fire;
        sel  = flush ? -1 : oldest_ready();
        fire = (sel >= 0) && issue_ready;
        chk("issue_valid", issue_valid, sel >= 0);
        chk("issue_rd_tag", issue_rd_tag, sel >= 0 ? model[sel].rd_tag : 0);
        chk("issue_opcode", issue_opcode, sel >= 0 ? model[sel].opc : 0);
        chk("issue_rs_data", issue_rs_data, sel >= 0 ? model[sel].rs_data : 0);
        chk("issue_rt_data", issue_rt_data, sel >= 0 ? model[sel].rt_data : 0);
        chk("dispatch_ready", dispatch_ready, !flush && (model.size() < DEPTH || fire));
        chk("count", count, model.size());
    endtask

    task automatic model_edge();
        int       sel;
        bit       fire, dfire;
        logic [XLEN-1:0] d;
        m_entry_t e;
        if (flush) begin
            model.delete();
            return;
        end
        sel   = oldest_ready();
        fire  = (sel >= 0) && issue_ready;
        dfire = dispatch_valid && (model.size() < DEPTH || fire);
        if (fire) model.delete(sel);
        foreach (model[i]) begin
            if (!model[i].rs_val && cdb_lookup(model[i].rs_tag, d)) begin
                model[i].rs_data = d; model[i].rs_val = 1;
            end
            if (!model[i].rt_val && cdb_lookup(model[i].rt_tag, d)) begin
                model[i].rt_data = d; model[i].rt_val = 1;
            end
        end
        if (dfire) begin
            e.rd_tag = dispatch_rd_tag;   e.opc = dispatch_opcode;
            e.rs_data = dispatch_rs_data; e.rt_data = dispatch_rt_data;
            e.rs_tag = dispatch_rs_tag;   e.rt_tag = dispatch_rt_tag;
            e.rs_val = dispatch_rs_val;   e.rt_val = dispatch_rt_val;
`ifdef ISSUE_QUEUE_CDB_BYPASS_EN
            if (!e.rs_val && cdb_lookup(e.rs_tag, d)) begin e.rs_data = d; e.rs_val = 1; end
            if (!e.rt_val && cdb_lookup(e.rt_tag, d)) begin e.rt_data = d; e.rt_val = 1; end
`endif
            model.push_back(e);
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        last_iv = issue_valid; last_dr = dispatch_ready; last_rd = issue_rd_tag;
        last_rs = issue_rs_data; last_cnt = count;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dispatch_valid = 0; cdb_valid = '0; flush = 0;
    endtask

    task automatic set_disp(input logic [TAG_W-1:0] rd, input logic [TAG_W-1:0] rs_tag,
                            input logic rs_val, input logic [XLEN-1:0] rs_data);
        dispatch_valid = 1; dispatch_rd_tag = rd; dispatch_opcode = rd[OPC_W-1:0];
        dispatch_rs_tag = rs_tag; dispatch_rs_val = rs_val; dispatch_rs_data = rs_data;
        dispatch_rt_tag = 6'd63; dispatch_rt_val = 1; dispatch_rt_data = 32'h100 + rd;
    endtask

    task automatic set_cdb(input int p, input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] data);
        cdb_valid[p] = 1'b1;
        cdb_tag[p*TAG_W +: TAG_W] = tag;
        cdb_data[p*XLEN +: XLEN]  = data;
    endtask

    initial begin
        reset = 1; flush = 0; issue_ready = 0;
        dispatch_valid = 0; dispatch_rs_data = '0; dispatch_rt_data = '0;
        dispatch_rs_tag = '0; dispatch_rt_tag = '0; dispatch_rs_val = 0; dispatch_rt_val = 0;
        dispatch_opcode = '0; dispatch_rd_tag = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0;

        @(negedge clk);
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_dispatch_ready", dispatch_ready, 1);
        chk("rst_count", count, 0);
        chk("rst_issue_rs_data", issue_rs_data, 0);
        @(posedge clk); #1;
        reset = 0;

        // In-order issue of three ready instructions.
        issue_ready = 1;
        set_disp(5, 0, 1, 32'h5); step(); chk("s1_empty_issue", last_iv, 0);
        set_disp(6, 0, 1, 32'h6); step(); chk("s1_rd0", last_rd, 5);
        set_disp(7, 0, 1, 32'h7); step(); chk("s1_rd1", last_rd, 6);
        idle(); step(); chk("s1_rd2", last_rd, 7);
        step(); chk("s1_count_zero", last_cnt, 0);

        // Younger ready entry bypasses an older waiting one; CDB port 1 wakes it.
        issue_ready = 0;
        set_disp(1, 9, 0, 32'h0); step();
        set_disp(2, 0, 1, 32'h2); step();
        idle(); issue_ready = 1; set_cdb(1, 9, 32'hDEAD); step();
        chk("s2_first_rd", last_rd, 2);
        idle(); step();
        chk("s2_second_rd", last_rd, 1);
        chk("s2_woken_data", last_rs, 32'hDEAD);

        // Full queue, then one-in/one-out.
        issue_ready = 0;
        for (int i = 0; i < DEPTH; i++) begin
            set_disp(TAG_W'(10 + i), 0, 1, 32'(i)); step();
        end
        idle(); step();
        chk("s3_full_ready", last_dr, 0);
        chk("s3_full_count", last_cnt, DEPTH);
        issue_ready = 1; set_disp(20, 0, 1, 32'h20); step();
        chk("s3_swap_ready", last_dr, 1);
        chk("s3_swap_rd", last_rd, 10);
        idle(); issue_ready = 0; step();
        chk("s3_count_held", last_cnt, DEPTH);
        flush = 1; step(); idle();

        // Two ports broadcast the same tag; port 0 wins.
        set_disp(30, 3, 0, 32'h0); step();
        idle(); set_cdb(0, 3, 32'h11); set_cdb(1, 3, 32'h22); step();
        idle(); issue_ready = 1; step();
        chk("s4_issue", last_iv, 1);
        chk("s4_port0_wins", last_rs, 32'h11);

        // Flush with a concurrent dispatch.
        for (int i = 0; i < 4; i++) begin
            set_disp(TAG_W'(40 + i), 50, 0, 32'h0); step();
        end
        idle(); flush = 1; set_disp(44, 0, 1, 32'h44); step();
        chk("s5_flush_no_issue", last_iv, 0);
        chk("s5_flush_no_dispatch", last_dr, 0);
        idle(); step();
        chk("s5_count_zero", last_cnt, 0);
        chk("s5_nothing_written", last_iv, 0);

        // Same-cycle CDB broadcast at dispatch.
        issue_ready = 0;
        set_disp(60, 12, 0, 32'h0); set_cdb(0, 12, 32'h1234); step();
        idle(); step();
`ifdef ISSUE_QUEUE_CDB_BYPASS_EN
        chk("s6_bypass_ready", last_iv, 1);
        issue_ready = 1; step();
        chk("s6_bypass_data", last_rs, 32'h1234);
`else
        chk("s6_no_bypass", last_iv, 0);
`endif
        flush = 1; step(); idle();

        // Randomized traffic with one asynchronous reset in the middle.
        for (int c = 0; c < 3000; c++) begin
            flush            = ($urandom_range(0, 99) < 3);
            issue_ready      = ($urandom_range(0, 99) < 50);
            dispatch_valid   = ($urandom_range(0, 99) < 60);
            dispatch_rd_tag  = TAG_W'($urandom);
            dispatch_opcode  = OPC_W'($urandom);
            dispatch_rs_tag  = TAG_W'($urandom_range(0, 7));
            dispatch_rt_tag  = TAG_W'($urandom_range(0, 7));
            dispatch_rs_val  = $urandom_range(0, 1) == 1;
            dispatch_rt_val  = $urandom_range(0, 1) == 1;
            dispatch_rs_data = $urandom;
            dispatch_rt_data = $urandom;
            cdb_valid        = NUM_CDB'($urandom_range(0, 3));
            for (int p = 0; p < NUM_CDB; p++) begin
                cdb_tag[p*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, 7));
                cdb_data[p*XLEN +: XLEN]  = $urandom;
            end
            if (c == 1500) begin
                #2 reset = 1;
                @(negedge clk);
                chk("midrst_issue_valid", issue_valid, 0);
                chk("midrst_dispatch_ready", dispatch_ready, !flush);
                chk("midrst_count", count, 0);
                chk("midrst_issue_rd", issue_rd_tag, 0);
                model.delete();
                @(posedge clk); #1;
                reset = 0;
            end else begin
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/generic_issue_queue.md
GENERIC_ISSUE_QUEUE -- requirements
Module: generic_issue_queue

Interface
REQ-001 Parameter DEPTH, 8, number of entries; legal values 2..16.
REQ-002 Parameter XLEN, 32, operand data width.
REQ-003 Parameter TAG_W, 6, physical tag width.
REQ-004 Parameter OPC_W, 4, opcode width.
REQ-005 Parameter NUM_CDB, 2, number of CDB broadcast ports.
REQ-006 The port list SHALL be exactly as follows (name  direction  width  meaning):
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous kill of all entries.
- dispatch_valid  in  1  dispatcher offers an instruction.
- dispatch_ready  out  1  queue accepts the offered instruction this cycle.
- dispatch_rs_data/dispatch_rt_data  in  XLEN  operand data.
- dispatch_rs_tag/dispatch_rt_tag  in  TAG_W  operand tags.
- dispatch_rs_val/dispatch_rt_val  in  1  operand data already valid.
- dispatch_opcode  in  OPC_W  opcode.
- dispatch_rd_tag  in  TAG_W  destination tag.
- cdb_valid  in  NUM_CDB  per-port broadcast valid.
- cdb_tag  in  NUM_CDB*TAG_W  packed tags; port p occupies bits [p*TAG_W +: TAG_W].
- cdb_data  in  NUM_CDB*XLEN  packed data, packed the same way.
- issue_valid  out  1  an issuable entry is presented.
- issue_ready  in  1  execution unit accepts.
- issue_rs_data/issue_rt_data  out  XLEN  operands.
- issue_rd_tag  out  TAG_W  destination tag.
- issue_opcode  out  OPC_W  opcode.
- count  out  $clog2(DEPTH+1)  number of valid entries.

Function
REQ-007 Entries SHALL be kept compacted and age-ordered: slot 0 is oldest, slots 0..count-1 are valid, and slots at count and above are invalid.
REQ-008 An entry SHALL be ready when it is valid and both rs_val and rt_val are set.
REQ-009 issue_valid SHALL be the OR of all ready flags; the lowest-index ready slot (the oldest) SHALL drive the issue_* outputs.
REQ-010 When issue_valid is 0, all issue_* data outputs SHALL be 0.
REQ-011 An issue fire SHALL be issue_valid && issue_ready && !flush.
- On a fire, the selected entry is removed and every entry above it shifts down one slot on the next edge.
REQ-012 dispatch_ready SHALL be (count < DEPTH) || issue fire.
- This path is combinational from issue_ready.
REQ-013 A dispatch fire SHALL be dispatch_valid && dispatch_ready && !flush.
- The new entry is written at slot count, or at slot count-1 when an issue fires in the same cycle.
REQ-014 Simultaneous dispatch and issue SHALL both complete in one cycle, leaving count unchanged; on a full queue this allows one-in/one-out throughput.
REQ-015 CDB wakeup: every valid entry with an operand val=0 and tag equal to a cdb_tag whose cdb_valid is set SHALL capture that port's data and set val.
- The captured value is written into the entry's post-shift slot.
- If several ports match the same tag, the lowest port index wins.
REQ-016 An operand woken in cycle N SHALL make its entry eligible for issue in cycle N+1; there is no same-cycle wakeup-to-issue.
REQ-017 count SHALL be incremented on a dispatch-only fire, decremented on an issue-only fire, and held otherwise.
REQ-018 flush SHALL clear every valid bit and set count to 0 on the next edge.
- flush takes priority over dispatch and issue.
- issue_valid and dispatch_ready SHALL be forced to 0 while flush is asserted.

Reset
REQ-019 reset SHALL asynchronously clear every entry field to 0 and set count to 0.
- issue_valid=0, dispatch_ready=1 and all issue_* outputs are 0 during reset.
REQ-020 A reset asserted mid-operation SHALL discard all entries, with no partial shift completed.

Configuration
REQ-021 When macro ISSUE_QUEUE_CDB_BYPASS_EN is defined, a dispatched operand with val=0 whose tag matches a valid CDB port in the dispatch cycle SHALL be written with that port's data and val=1.
REQ-022 When ISSUE_QUEUE_CDB_BYPASS_EN is undefined, the dispatched operand SHALL be written as given; the dispatcher is then responsible for resolving same-cycle broadcasts.

Structure
REQ-023 Package issue_queue_pkg SHALL hold the default parameter constants and the entry typedef iq_entry_t (valid, rd_tag, opcode, rs/rt data, tag and val), sized from the package constants.
REQ-024 The oldest-ready priority encoder SHALL be a sub-module iq_oldest_picker, with a DEPTH-bit ready vector in and a one-hot grant plus index out.

Verification
REQ-025 A bench SHALL cover the following directed scenarios:
- Dispatch 3 entries, all operands valid, issue_ready=1 -> issued in dispatch order with rd_tag 5, 6, 7 on consecutive cycles; count returns to 0.
- Slot0 waits on tag 9, slot1 ready -> slot1 issues first; cdb_valid[1]=1, tag=9, data=0xDEAD -> slot0 issues the next cycle with rs_data=0xDEAD.
- Fill to DEPTH=8 with issue_ready=0 -> dispatch_ready=0 and count=8; raise issue_ready together with dispatch_valid -> one in and one out, count stays 8.
- CDB ports 0 and 1 both broadcast tag 3 (data 0x11 and 0x22) -> the waiting entry captures 0x11.
- flush with 4 entries plus a concurrent dispatch -> count=0 next cycle, nothing issues, and the dispatched instruction is not written.
- With ISSUE_QUEUE_CDB_BYPASS_EN, dispatch rs_tag=12 (val=0) while the CDB broadcasts tag 12 -> the entry is ready next cycle; without the macro, the entry stays not ready.
